// File: rtl/hall_call_if.sv
// Dispatcher handshake bundle: one hall call offered at a time over valid/ready.
interface hall_call_if;
  logic       call_valid;
  logic [3:0] call_floor;
  logic       call_up;
  logic       call_ready;

  // The tracker offers calls; the dispatcher accepts them.
  modport master (output call_valid, output call_floor, output call_up, input call_ready);
  modport slave  (input call_valid, input call_floor, input call_up, output call_ready);
endinterface

// File: rtl/hall_call_tracker.sv
// Hall call tracker: latches spawned passengers into pending up/down hall calls,
// counts waiting people per floor, offers unassigned calls to the dispatcher one
// at a time (round-robin over entries floor*2+up) and clears calls on car arrival.
module hall_call_tracker #(
  parameter int NUM_FLOORS = 12,
  parameter int CNT_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    simState,
  input  logic [NUM_FLOORS-1:0]         floorsRequested,
  input  logic [NUM_FLOORS-1:0]         floorDestinations,
  input  logic                          arrive_valid,
  input  logic [3:0]                    arrive_floor,
  input  logic                          arrive_up,
  hall_call_if.master                   call,
  output logic [NUM_FLOORS-1:0]         pending_up,
  output logic [NUM_FLOORS-1:0]         pending_down,
  output logic [NUM_FLOORS*CNT_W-1:0]   waitCount
);

  localparam logic [1:0] ST_START  = 2'd0;
  localparam logic [1:0] ST_SIM    = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;
  localparam logic [1:0] ST_ENDING = 2'd3;

  localparam int          NE   = 2 * NUM_FLOORS;
  localparam int          PW   = $clog2(NE);
  localparam logic [PW:0] NE_L = (PW+1)'(NE);

  logic [NUM_FLOORS-1:0] pend_up_q, pend_up_d;
  logic [NUM_FLOORS-1:0] pend_dn_q, pend_dn_d;
  logic [NUM_FLOORS-1:0] asg_up_q,  asg_up_d;
  logic [NUM_FLOORS-1:0] asg_dn_q,  asg_dn_d;
  logic [CNT_W-1:0]      cnt_q [NUM_FLOORS];
  logic [CNT_W-1:0]      cnt_d [NUM_FLOORS];
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  vld_q, vld_d;
  logic [3:0]            floor_q, floor_d;
  logic                  up_q, up_d;

  logic [NE-1:0]         elig;
  logic [PW:0]           cand;
  logic [PW:0]           nxt;
  logic                  found;
  logic                  arr_ok;

  // Next-state: handshake, then arrival, then dispatch search, then new requests.
  always_comb begin
    pend_up_d = pend_up_q;
    pend_dn_d = pend_dn_q;
    asg_up_d  = asg_up_q;
    asg_dn_d  = asg_dn_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    vld_d     = vld_q;
    floor_d   = floor_q;
    up_d      = up_q;
    elig      = '0;
    cand      = '0;
    nxt       = '0;
    found     = 1'b0;
    arr_ok    = arrive_valid && (int'(arrive_floor) < NUM_FLOORS);

    case (simState)
      ST_SIM, ST_PAUSE: begin
        // An accepted offer marks its entry assigned and empties the slice,
        // even while paused.
        if (vld_q && call.call_ready) begin
          if (up_q) asg_up_d[floor_q] = 1'b1;
          else      asg_dn_d[floor_q] = 1'b1;
          vld_d = 1'b0;
        end

        if (simState == ST_SIM) begin
          // Arrival clears the served direction; it also overrides a same-cycle
          // accept of the same entry because it clears the assigned bit afterwards.
          if (arr_ok) begin
            if (arrive_up) begin
              pend_up_d[arrive_floor] = 1'b0;
              asg_up_d[arrive_floor]  = 1'b0;
              if (!pend_dn_d[arrive_floor]) cnt_d[arrive_floor] = '0;
            end else begin
              pend_dn_d[arrive_floor] = 1'b0;
              asg_dn_d[arrive_floor]  = 1'b0;
              if (!pend_up_d[arrive_floor]) cnt_d[arrive_floor] = '0;
            end
            if (vld_q && (floor_q == arrive_floor) && (up_q == arrive_up)) vld_d = 1'b0;
          end

          // Search uses post-arrival state so a just-served call is never offered.
          if (!vld_q) begin
            for (int f = 0; f < NUM_FLOORS; f++) begin
              elig[2*f+1] = pend_up_d[f] & ~asg_up_d[f];
              elig[2*f]   = pend_dn_d[f] & ~asg_dn_d[f];
            end
            for (int k = 0; k < NE; k++) begin
              cand = {1'b0, ptr_q} + (PW+1)'(k);
              if (cand >= NE_L) cand = cand - NE_L;
              if (!found && elig[cand[PW-1:0]]) begin
                found   = 1'b1;
                vld_d   = 1'b1;
                floor_d = cand[PW-1:1];
                up_d    = cand[0];
                nxt     = cand + 1'b1;
                if (nxt == NE_L) nxt = '0;
                ptr_d   = nxt[PW-1:0];
              end
            end
          end

          // New spawns are applied last so they survive a same-cycle arrival.
          for (int i = 0; i < NUM_FLOORS; i++) begin
            if (floorsRequested[i]) begin
              if (floorDestinations[i]) pend_up_d[i] = 1'b1;
              else                      pend_dn_d[i] = 1'b1;
              if (cnt_d[i] != {CNT_W{1'b1}}) cnt_d[i] = cnt_d[i] + 1'b1;
            end
          end
        end
      end
      default: begin
        pend_up_d = '0;
        pend_dn_d = '0;
        asg_up_d  = '0;
        asg_dn_d  = '0;
        cnt_d     = '{default: '0};
        ptr_d     = '0;
        vld_d     = 1'b0;
        floor_d   = '0;
        up_d      = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_up_q <= '0;
      pend_dn_q <= '0;
      asg_up_q  <= '0;
      asg_dn_q  <= '0;
      cnt_q     <= '{default: '0};
      ptr_q     <= '0;
      vld_q     <= 1'b0;
      floor_q   <= '0;
      up_q      <= 1'b0;
    end else begin
      pend_up_q <= pend_up_d;
      pend_dn_q <= pend_dn_d;
      asg_up_q  <= asg_up_d;
      asg_dn_q  <= asg_dn_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      vld_q     <= vld_d;
      floor_q   <= floor_d;
      up_q      <= up_d;
    end
  end

  assign call.call_valid = vld_q;
  assign call.call_floor = floor_q;
  assign call.call_up    = up_q;
  assign pending_up      = pend_up_q;
  assign pending_down    = pend_dn_q;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_wc
    assign waitCount[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule
